// File: rtl/dp_pkg.sv
// Shared definitions for the debug-port host sequencer and dp_trx: FSM states,
// response codes and the bit positions of the dp_ctrl / dp_fsm_ctrl buses.
package dp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SEND,
        ST_WR_WAIT,
        ST_WR_ACK,
        ST_WR_PAR,
        ST_WR_STOP,
        ST_RD_SEND,
        ST_RD_WAIT,
        ST_RD_RCV,
        ST_RESP,
        ST_GAP
    } dp_state_e;

    typedef enum logic [1:0] {
        DP_OK      = 2'd0,
        DP_NACK    = 2'd1,
        DP_PARITY  = 2'd2,
        DP_TIMEOUT = 2'd3
    } dp_err_e;

    localparam int DP_CTRL_STATE_CHG = 5;
    localparam int DP_CTRL_WR_SEND   = 4;
    localparam int DP_CTRL_RD_SEND   = 3;
    localparam int DP_CTRL_RD_RCV    = 2;
    localparam int DP_CTRL_SEND_MODE = 1;
    localparam int DP_CTRL_CNT_ENA   = 0;

    // Reply bits are raw line levels: ACK and good parity read low, STOP reads high.
    localparam int DP_FSM_RCV_START  = 5;
    localparam int DP_FSM_RCV_ACK    = 4;
    localparam int DP_FSM_RCV_PARITY = 3;
    localparam int DP_FSM_RCV_STOP   = 2;
    localparam int DP_FSM_RCV_DONE   = 1;
    localparam int DP_FSM_SEND_DONE  = 0;

    function automatic int dp_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dp_wait_timer.sv
// Clear/enable cycle counter with a terminal-count flag at MAX-1; saturates there,
// so it never wraps while the owning state lingers.
module dp_wait_timer import dp_pkg::*; #(
    parameter int MAX = 64
) (
    input  logic dp_clk,
    input  logic dp_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = dp_cnt_w(MAX);
    localparam logic [W-1:0] LAST = W'((MAX > 0) ? MAX - 1 : 0);

    logic [W-1:0] cnt;

    always_ff @(posedge dp_clk) begin
        if (dp_rst || clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/dp_host_fsm.sv
// Host-side debug-port transaction sequencer: takes one request per handshake,
// steers dp_trx through send/wait/reply, and returns a held status/data response.
module dp_host_fsm import dp_pkg::*; #(
    parameter int N_DW    = 32,
    parameter int N_DM    = 4,
    parameter int TMO_CYC = 64,
    parameter int GAP_CYC = 2
) (
    input  logic            dp_clk,
    input  logic            dp_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_type,
    input  logic [N_DW-1:0] req_addr,
    input  logic [N_DW-1:0] req_data,
    input  logic [N_DM-1:0] req_strb,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [1:0]      resp_err,
    output logic [N_DW-1:0] resp_rdata,
    input  logic [N_DW-1:0] trx_rdata,
    input  logic            trx_rdata_err,
    output logic            trx_req_type,
    output logic [N_DW-1:0] trx_req_addr,
    output logic [N_DW-1:0] trx_req_data,
    output logic [N_DM-1:0] trx_req_strb,
    output logic [5:0]      dp_ctrl,
    input  logic [5:0]      dp_fsm_ctrl
);
    dp_state_e       state, next_state;
    dp_err_e         err_q;
    logic [N_DW-1:0] rdata_q;
    logic            first_q;
    logic            hs, in_wait, tmo_tc, gap_tc;

    assign resp_valid = (state == ST_RESP);
    assign req_ready  = (state == ST_IDLE) && !resp_valid && !dp_rst;
    assign hs         = req_valid && req_ready;
    assign in_wait    = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    dp_wait_timer #(.MAX(TMO_CYC)) u_tmo (
        .dp_clk (dp_clk),
        .dp_rst (dp_rst),
        .clr    (!in_wait),
        .en     (in_wait),
        .tc     (tmo_tc)
    );

    dp_wait_timer #(.MAX(GAP_CYC)) u_gap (
        .dp_clk (dp_clk),
        .dp_rst (dp_rst),
        .clr    (state != ST_GAP),
        .en     (state == ST_GAP),
        .tc     (gap_tc)
    );

    always_comb begin
        next_state = state;
        dp_ctrl    = '0;
        unique case (state)
            ST_IDLE:
                if (hs) next_state = req_type ? ST_WR_SEND : ST_RD_SEND;
            ST_WR_SEND, ST_RD_SEND: begin
                // First cycle in state pulses state_chg so dp_trx reloads its bit counter.
                dp_ctrl[DP_CTRL_STATE_CHG] = first_q;
                dp_ctrl[DP_CTRL_CNT_ENA]   = !first_q;
                dp_ctrl[DP_CTRL_SEND_MODE] = 1'b1;
                dp_ctrl[DP_CTRL_WR_SEND]   = (state == ST_WR_SEND);
                dp_ctrl[DP_CTRL_RD_SEND]   = (state == ST_RD_SEND);
                if (dp_fsm_ctrl[DP_FSM_SEND_DONE] && !first_q)
                    next_state = (state == ST_WR_SEND) ? ST_WR_WAIT : ST_RD_WAIT;
            end
            ST_WR_WAIT, ST_RD_WAIT:
                if (dp_fsm_ctrl[DP_FSM_RCV_START])
                    next_state = (state == ST_WR_WAIT) ? ST_WR_ACK : ST_RD_RCV;
                else if (tmo_tc)
                    next_state = ST_RESP;
            ST_WR_ACK:  next_state = ST_WR_PAR;
            ST_WR_PAR:  next_state = ST_WR_STOP;
            ST_WR_STOP: next_state = ST_RESP;
            ST_RD_RCV: begin
                dp_ctrl[DP_CTRL_STATE_CHG] = first_q;
                dp_ctrl[DP_CTRL_CNT_ENA]   = !first_q;
                dp_ctrl[DP_CTRL_RD_RCV]    = 1'b1;
                if (dp_fsm_ctrl[DP_FSM_RCV_DONE] && !first_q)
                    next_state = ST_RESP;
            end
            ST_RESP:
                if (resp_ready) next_state = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:
                if (gap_tc) next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge dp_clk) begin
        if (dp_rst) begin
            state        <= ST_IDLE;
            first_q      <= 1'b0;
            err_q        <= DP_OK;
            rdata_q      <= '0;
            trx_req_type <= 1'b0;
            trx_req_addr <= '0;
            trx_req_data <= '0;
            trx_req_strb <= '0;
        end else begin
            state   <= next_state;
            first_q <= (next_state != state);
            if (hs) begin
                trx_req_type <= req_type;
                trx_req_addr <= req_addr;
                trx_req_data <= req_data;
                trx_req_strb <= req_strb;
                err_q        <= DP_OK;
                rdata_q      <= '0;
            end
            // Only the first reply error is kept; later bits cannot overwrite it.
            case (state)
                ST_WR_WAIT, ST_RD_WAIT:
                    if (!dp_fsm_ctrl[DP_FSM_RCV_START] && tmo_tc) err_q <= DP_TIMEOUT;
                ST_WR_ACK:
                    if (dp_fsm_ctrl[DP_FSM_RCV_ACK] && err_q == DP_OK) err_q <= DP_NACK;
                ST_WR_PAR:
                    if (dp_fsm_ctrl[DP_FSM_RCV_PARITY] && err_q == DP_OK) err_q <= DP_PARITY;
                ST_WR_STOP:
                    if (!dp_fsm_ctrl[DP_FSM_RCV_STOP] && err_q == DP_OK) err_q <= DP_PARITY;
                ST_RD_RCV:
                    if (next_state == ST_RESP) begin
                        if (trx_rdata_err) err_q   <= DP_PARITY;
                        else               rdata_q <= trx_rdata;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_host_fsm.sv
// Self-checking bench for dp_host_fsm: a table of transactions played against a
// small behavioural target, with expected responses queued at request time.
module tb_dp_host_fsm;
    localparam int TMO      = 64;
    localparam int GAP      = 2;
    localparam int SEND_LEN = 3;
    localparam int RCV_LEN  = 3;

    localparam logic [5:0] C_WR_FIRST  = 6'b110010;
    localparam logic [5:0] C_WR_LATER  = 6'b010011;
    localparam logic [5:0] C_RD_FIRST  = 6'b101010;
    localparam logic [5:0] C_RD_LATER  = 6'b001011;
    localparam logic [5:0] C_RCV_FIRST = 6'b100100;
    localparam logic [5:0] C_RCV_LATER = 6'b000101;

    logic        dp_clk = 1'b0;
    logic        dp_rst = 1'b1;
    logic        req_valid = 1'b0, req_type = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic [3:0]  req_strb = '0;
    logic        req_ready, resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] trx_rdata = '0;
    logic        trx_rdata_err = 1'b0;
    logic        trx_req_type;
    logic [31:0] trx_req_addr, trx_req_data;
    logic [3:0]  trx_req_strb;
    logic [5:0]  dp_ctrl, dp_fsm_ctrl;
    logic        rcv_start = 0, rcv_ack = 0, rcv_parity = 0, rcv_stop = 0, rcv_done = 0, send_done = 0;

    assign dp_fsm_ctrl = {rcv_start, rcv_ack, rcv_parity, rcv_stop, rcv_done, send_done};

    always #5 dp_clk = ~dp_clk;

    dp_host_fsm #(.N_DW(32), .N_DM(4), .TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
        .dp_clk        (dp_clk),
        .dp_rst        (dp_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_strb      (req_strb),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_err      (resp_err),
        .resp_rdata    (resp_rdata),
        .trx_rdata     (trx_rdata),
        .trx_rdata_err (trx_rdata_err),
        .trx_req_type  (trx_req_type),
        .trx_req_addr  (trx_req_addr),
        .trx_req_data  (trx_req_data),
        .trx_req_strb  (trx_req_strb),
        .dp_ctrl       (dp_ctrl),
        .dp_fsm_ctrl   (dp_fsm_ctrl)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;      // wait cycles before START; >= TMO means never
        logic        ack, par, stop;
        logic [31:0] rd;
        logic        rd_err;
        int          hold;     // cycles resp_ready is held low once resp_valid rises
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
    } txn_t;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    txn_t tbl [9];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic step();
        @(posedge dp_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input txn_t t);
        int   w;
        exp_t e;
        w = 0;
        while (!req_ready && w < 20) begin step(); w++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_type = t.wr; req_addr = t.addr; req_data = t.data; req_strb = t.strb;
        sb_q.push_back('{t.e_err, t.e_rdata});
        step();
        req_valid = 0;
        check("trx_req_type", trx_req_type, t.wr);
        check("trx_req_addr", trx_req_addr, t.addr);
        check("trx_req_data", trx_req_data, t.data);
        check("trx_req_strb", trx_req_strb, t.strb);
        for (int i = 0; i < SEND_LEN; i++) begin
            check("send_ctrl", dp_ctrl, (i == 0) ? (t.wr ? C_WR_FIRST : C_RD_FIRST)
                                                 : (t.wr ? C_WR_LATER : C_RD_LATER));
            send_done = (i == SEND_LEN - 1);
            step();
        end
        send_done = 0;
        check("wait_ctrl", dp_ctrl, 0);
        for (int i = 0; i < TMO; i++) begin
            rcv_start = (i == t.dly);
            if (i == TMO - 1 && t.dly >= TMO) check("no_early_timeout", resp_valid, 0);
            step();
            if (i == t.dly) break;
        end
        rcv_start = 0;
        if (t.dly < TMO) begin
            if (t.wr) begin
                rcv_ack = t.ack;     step(); rcv_ack = 0;
                rcv_parity = t.par;  step(); rcv_parity = 0;
                rcv_stop = t.stop;   step(); rcv_stop = 0;
            end else begin
                trx_rdata = t.rd; trx_rdata_err = t.rd_err;
                for (int i = 0; i < RCV_LEN; i++) begin
                    check("rcv_ctrl", dp_ctrl, (i == 0) ? C_RCV_FIRST : C_RCV_LATER);
                    rcv_done = (i == RCV_LEN - 1);
                    step();
                end
                rcv_done = 0;
            end
        end
        check("resp_latency", resp_valid, 1);
        w = 0;
        while (!resp_valid && w < 100) begin step(); w++; end
        if (sb_q.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL sb_empty: got no expected entry, required one");
            e = '{2'd0, 32'h0};
        end else begin
            e = sb_q.pop_front();
        end
        for (int h = 0; h < t.hold; h++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_err", resp_err, e.err);
            check("hold_rdata", resp_rdata, e.rdata);
            check("hold_req_ready", req_ready, 0);
            step();
        end
        check("resp_err", resp_err, e.err);
        check("resp_rdata", resp_rdata, e.rdata);
        resp_ready = 1;
        step();
        resp_ready = 0; trx_rdata = '0; trx_rdata_err = 0;
        for (int g = 0; g < GAP; g++) begin
            check("gap_req_ready", req_ready, 0);
            check("gap_ctrl", dp_ctrl, 0);
            check("gap_valid", resp_valid, 0);
            step();
        end
        check("post_gap_ready", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0,   1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 0,  2'd0, 32'h0};
        tbl[1] = '{1'b0, 32'h2000_0000, 32'h0,         4'h0, 2,   1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 0,  2'd0, 32'h1234_5678};
        tbl[2] = '{1'b0, 32'h2000_0004, 32'h0,         4'h0, 1,   1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1, 0,  2'd2, 32'h0};
        tbl[3] = '{1'b1, 32'h1000_0044, 32'h1111_2222, 4'h3, 64,  1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 0,  2'd3, 32'h0};
        tbl[4] = '{1'b1, 32'h1000_0048, 32'h3333_4444, 4'hC, 63,  1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 0,  2'd0, 32'h0};
        tbl[5] = '{1'b1, 32'h1000_004C, 32'h5555_6666, 4'h1, 0,   1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 10, 2'd1, 32'h0};
        tbl[6] = '{1'b1, 32'h1000_0050, 32'h7777_8888, 4'h2, 0,   1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 0,  2'd2, 32'h0};
        tbl[7] = '{1'b1, 32'h1000_0054, 32'h9999_AAAA, 4'h4, 3,   1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0,  2'd2, 32'h0};
        tbl[8] = '{1'b1, 32'h1000_0058, 32'hBBBB_CCCC, 4'h8, 0,   1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 0,  2'd1, 32'h0};

        step(); step(); step();
        check("rst_req_ready", req_ready, 0);
        check("rst_dp_ctrl", dp_ctrl, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_trx_addr", trx_req_addr, 0);
        dp_rst = 0;
        step();

        for (int k = 0; k < 9; k++) run_txn(tbl[k]);

        // Reset while receiving read data: aborts with no response.
        req_valid = 1; req_type = 0; req_addr = 32'h2000_0100;
        step();
        req_valid = 0;
        for (int i = 0; i < SEND_LEN; i++) begin
            send_done = (i == SEND_LEN - 1);
            step();
        end
        send_done = 0;
        rcv_start = 1; step(); rcv_start = 0;
        check("pre_rst_ctrl", dp_ctrl, C_RCV_FIRST);
        step();
        dp_rst = 1;
        step();
        check("mid_rst_ctrl", dp_ctrl, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        dp_rst = 0;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_resp", resp_valid, 0);
        end
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
